count_sequence_checker: RTL and testbench
=========================================

# count_sequence_checker

Downstream consumer of the 5-bit free-running counter. Samples the counter's `Count` output every clock and checks that it only holds or increments by one modulo 2^WIDTH. It pulses on each step and each wrap, keeps a saturating wrap tally, and latches sticky errors for illegal jumps or over-long stalls. It is used inside benches and bring-up logic to replace ad-hoc `$monitor` inspection of the counter.

## Interface

- `WIDTH`, default 5: width of the monitored count.
- `MAX_HOLD`, default 16: consecutive unchanged cycles that trigger a stall error. Legal range is 1..255.
- `WRAP_W`, default 8: width of the wrap tally.

Ports:

- `Clk`, input, 1: the single clock; all logic is on its rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Count`, input, WIDTH: monitored counter value. It must be synchronous to `Clk`.
- `Enable`, input, 1: checking enable.
- `Locked`, output, 1: high while in TRACK.
- `Step`, output, 1: one-cycle pulse on a legal +1 transition.
- `Wrap`, output, 1: one-cycle pulse on a transition from all-ones to 0. `Step` is also high on that cycle.
- `Wraps`, output, WRAP_W: saturating count of `Wrap` pulses.
- `Last_Good`, output, WIDTH: last value accepted as legal.
- `Err_Jump`, output, 1: sticky flag for an illegal transition.
- `Err_Stall`, output, 1: sticky flag for a hold reaching `MAX_HOLD` cycles.

## Operation

Internal state:
- `prev` (WIDTH bits).
- `hold_cnt` (8 bits).
- FSM with states IDLE, TRACK and FAULT.

Reset:
- State goes to IDLE; `prev`, `hold_cnt`, `Last_Good` and `Wraps` go to 0.
- `Locked`, `Step`, `Wrap`, `Err_Jump` and `Err_Stall` go to 0.
- `Reset` overrides every other input.

IDLE:
- When `Enable`=1: `prev`←`Count`, `Last_Good`←`Count`, `hold_cnt`←0, and the state moves to TRACK.
- No checking is done on this first sample.

TRACK, with `Enable`=1, each edge falls into exactly one case:
- `Count`==`prev`:
  - `hold_cnt`←`hold_cnt`+1.
  - If `hold_cnt`+1 == `MAX_HOLD`: `Err_Stall`←1 and the state moves to FAULT.
- `Count`==(`prev`+1) mod 2^WIDTH:
  - `Step` pulses.
  - `prev`←`Count`, `Last_Good`←`Count`, `hold_cnt`←0.
  - If `prev`==2^WIDTH−1 (so `Count`==0): `Wrap` pulses and `Wraps` increments, holding at 2^WIDTH_W−1 once saturated.
- Any other value:
  - `Err_Jump`←1 and the state moves to FAULT.
  - `prev` and `Last_Good` are unchanged, so `Last_Good` keeps the last legal value.

TRACK with `Enable`=0:
- The state moves to IDLE and `hold_cnt`←0. No classification is done that cycle.
- `Wraps`, `Last_Good` and the error flags are retained.

FAULT:
- Terminal. Only `Reset` leaves it; `Enable` is ignored.
- `Step` and `Wrap` stay 0, and all other outputs are frozen.

Arithmetic and boundaries:
- Increments are computed in WIDTH bits, so wrap-around is implicit.
- `hold_cnt` never exceeds `MAX_HOLD`.
- Counter self-restart to 0 from 31 is a legal wrap. A restart to 0 from any other value is a jump error.
- If a stall and a jump would coincide, only the case matching the current sample applies; the cases are exclusive.

## Timing

- All outputs are registered, with 1-cycle latency. A transition sampled at edge N appears on `Step`/`Wrap`/`Err_*` after edge N, and `Wraps`/`Last_Good` update at that same edge.
- `Step` and `Wrap` are high for exactly one cycle per transition.
- `Locked` rises after the edge that enters TRACK. It falls after the edge that leaves TRACK.
- `Err_Stall` is set at the `MAX_HOLD`-th consecutive edge with `Count`==`prev`. With the default, that is 16 unchanged edges after the last change.
- `Reset` asserted mid-sequence takes effect at the next edge. Outputs are zero after that edge, regardless of `Enable` or `Count`.
- Behaviour is undefined if `Count` changes asynchronously to `Clk`.

## Test plan

- Reset with `Enable`=1 and `Count`=7: all outputs are 0 after the edge. After `Reset` deasserts, the state reaches TRACK, `Locked`=1 and `Last_Good`=7.
- `Count` runs 0..31,0,1 with each value held 3 clocks: 33 `Step` pulses, one `Wrap` pulse on the 31→0 transition, `Wraps`=1, no errors.
- Counting 5,6, then `Count`=9: `Err_Jump`=1 the next cycle, FAULT entered, `Last_Good`=6, `Locked`=0. Further counting produces no `Step`.
- `Count` held at 12 for 16 edges in TRACK: `Err_Stall`=1 after the 16th edge. A hold of 15 edges followed by 13 gives no error and `Step`=1.
- `Enable` dropped on the same edge that `Count` jumps 3→20: no error and IDLE entered. `Enable` raised with `Count`=20 resumes TRACK with `Last_Good`=20.
- `WRAP_W`=2 with 5 wraps: `Wraps` saturates at 3. Reset mid-count returns `Wraps` to 0 and clears the sticky error flags.

Source files
------------

// File: rtl/count_sequence_checker.sv
// Watches a free-running counter and flags anything other than hold or +1 (mod 2^WIDTH).
// Pulses on each step/wrap, keeps a saturating wrap tally and sticky jump/stall errors.
module count_sequence_checker #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Count,
    input  logic              Enable,
    output logic              Locked,
    output logic              Step,
    output logic              Wrap,
    output logic [WRAP_W-1:0] Wraps,
    output logic [WIDTH-1:0]  Last_Good,
    output logic              Err_Jump,
    output logic              Err_Stall
);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [WIDTH-1:0]    last_good_q, last_good_d;
    logic [7:0]          hold_q, hold_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                step_q, step_d;
    logic                wrap_q, wrap_d;
    logic                err_jump_q, err_jump_d;
    logic                err_stall_q, err_stall_d;

    logic [WIDTH-1:0]    prev_inc;
    logic [7:0]          hold_inc;

    assign prev_inc = prev_q + WIDTH'(1);
    assign hold_inc = hold_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        last_good_d = last_good_q;
        hold_d      = hold_q;
        wraps_d     = wraps_q;
        step_d      = 1'b0;
        wrap_d      = 1'b0;
        err_jump_d  = err_jump_q;
        err_stall_d = err_stall_q;

        unique case (state_q)
            StIdle: begin
                // First sample only seeds the tracker; nothing to compare against yet.
                if (Enable) begin
                    prev_d      = Count;
                    last_good_d = Count;
                    hold_d      = 8'd0;
                    state_d     = StTrack;
                end
            end
            StTrack: begin
                if (!Enable) begin
                    hold_d  = 8'd0;
                    state_d = StIdle;
                end else if (Count == prev_q) begin
                    hold_d = hold_inc;
                    if (hold_inc == 8'(MAX_HOLD)) begin
                        err_stall_d = 1'b1;
                        state_d     = StFault;
                    end
                end else if (Count == prev_inc) begin
                    step_d      = 1'b1;
                    prev_d      = Count;
                    last_good_d = Count;
                    hold_d      = 8'd0;
                    if (prev_q == {WIDTH{1'b1}}) begin
                        wrap_d = 1'b1;
                        if (wraps_q != {WRAP_W{1'b1}}) begin
                            wraps_d = wraps_q + WRAP_W'(1);
                        end
                    end
                end else begin
                    err_jump_d = 1'b1;
                    state_d    = StFault;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            prev_q      <= '0;
            last_good_q <= '0;
            hold_q      <= 8'd0;
            wraps_q     <= '0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            err_jump_q  <= 1'b0;
            err_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            last_good_q <= last_good_d;
            hold_q      <= hold_d;
            wraps_q     <= wraps_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            err_jump_q  <= err_jump_d;
            err_stall_q <= err_stall_d;
        end
    end

    assign Locked    = (state_q == StTrack);
    assign Step      = step_q;
    assign Wrap      = wrap_q;
    assign Wraps     = wraps_q;
    assign Last_Good = last_good_q;
    assign Err_Jump  = err_jump_q;
    assign Err_Stall = err_stall_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: default instance plus a WRAP_W=2 instance on
// the same stimulus to exercise tally saturation.
module tb_count_sequence_checker;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] Count = 5'd0;
    logic       Enable = 1'b0;

    logic       locked, step, wrap, err_jump, err_stall;
    logic [7:0] wraps;
    logic [4:0] last_good;
    logic       locked2, step2, wrap2, err_jump2, err_stall2;
    logic [1:0] wraps2;
    logic [4:0] last_good2;

    int checks = 0;
    int errors = 0;

    count_sequence_checker dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Count     (Count),
        .Enable    (Enable),
        .Locked    (locked),
        .Step      (step),
        .Wrap      (wrap),
        .Wraps     (wraps),
        .Last_Good (last_good),
        .Err_Jump  (err_jump),
        .Err_Stall (err_stall)
    );

    count_sequence_checker #(.WRAP_W(2)) dut2 (
        .Clk       (Clk),
        .Reset     (Reset),
        .Count     (Count),
        .Enable    (Enable),
        .Locked    (locked2),
        .Step      (step2),
        .Wrap      (wrap2),
        .Wraps     (wraps2),
        .Last_Good (last_good2),
        .Err_Jump  (err_jump2),
        .Err_Stall (err_stall2)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reset, then enable with the given first sample so the checker enters TRACK.
    task automatic enter(input logic [4:0] v);
        Reset  = 1'b1;
        tick();
        Reset  = 1'b0;
        Enable = 1'b1;
        Count  = v;
        tick();
    endtask

    int n_step;
    int n_wrap;
    int wrap_at;
    int idx;

    initial begin
        // Reset dominates Enable/Count
        Reset  = 1'b1;
        Enable = 1'b1;
        Count  = 5'd7;
        tick();
        check("rst_locked", locked, 0);
        check("rst_step", step, 0);
        check("rst_wrap", wrap, 0);
        check("rst_wraps", wraps, 0);
        check("rst_last_good", last_good, 0);
        check("rst_err_jump", err_jump, 0);
        check("rst_err_stall", err_stall, 0);
        Reset = 1'b0;
        tick();
        check("enter_locked", locked, 1);
        check("enter_last_good", last_good, 7);

        // Full run 0..31,0,1, each value held 3 clocks
        enter(5'd0);
        n_step  = 0;
        n_wrap  = 0;
        wrap_at = -1;
        idx     = 0;
        for (int v = 1; v <= 33; v++) begin
            Count = 5'(v % 32);
            for (int h = 0; h < 3; h++) begin
                tick();
                if (step) n_step++;
                if (wrap) begin
                    n_wrap++;
                    wrap_at = idx;
                end
                idx++;
            end
        end
        check("run_steps", n_step, 33);
        check("run_wrap_pulses", n_wrap, 1);
        check("run_wrap_at", wrap_at, 31 * 3);
        check("run_wraps", wraps, 1);
        check("run_wraps_w2", wraps2, 1);
        check("run_err_jump", err_jump, 0);
        check("run_err_stall", err_stall, 0);
        check("run_last_good", last_good, 1);
        check("run_locked", locked, 1);

        // Illegal jump 6 -> 9
        enter(5'd5);
        Count = 5'd6;
        tick();
        check("jump_step6", step, 1);
        Count = 5'd9;
        tick();
        check("jump_err", err_jump, 1);
        check("jump_locked", locked, 0);
        check("jump_last_good", last_good, 6);
        check("jump_step", step, 0);
        n_step = 0;
        for (int v = 10; v < 13; v++) begin
            Count = 5'(v);
            tick();
            if (step) n_step++;
        end
        check("fault_steps", n_step, 0);
        check("fault_err_sticky", err_jump, 1);
        check("fault_last_good", last_good, 6);

        // Hold of 15 is fine, hold of 16 stalls
        enter(5'd12);
        for (int h = 0; h < 15; h++) tick();
        check("hold15_err_stall", err_stall, 0);
        check("hold15_locked", locked, 1);
        Count = 5'd13;
        tick();
        check("hold15_step", step, 1);
        check("hold15_err_after", err_stall, 0);
        for (int h = 0; h < 15; h++) tick();
        check("hold16_pre", err_stall, 0);
        tick();
        check("hold16_err_stall", err_stall, 1);
        check("hold16_locked", locked, 0);
        check("hold16_err_jump", err_jump, 0);

        // Enable drop masks the 3 -> 20 jump
        enter(5'd3);
        Enable = 1'b0;
        Count  = 5'd20;
        tick();
        check("endrop_err_jump", err_jump, 0);
        check("endrop_locked", locked, 0);
        check("endrop_step", step, 0);
        Enable = 1'b1;
        tick();
        check("resume_locked", locked, 1);
        check("resume_last_good", last_good, 20);
        Count = 5'd21;
        tick();
        check("resume_step", step, 1);

        // Five wraps: WRAP_W=2 saturates at 3
        enter(5'd0);
        for (int w = 0; w < 5; w++) begin
            for (int v = 1; v <= 32; v++) begin
                Count = 5'(v % 32);
                tick();
            end
        end
        check("sat_wraps", wraps, 5);
        check("sat_wraps_w2", wraps2, 3);
        check("sat_err_jump", err_jump, 0);
        Count = 5'd7;
        tick();
        check("sat_jump_err", err_jump, 1);
        Reset = 1'b1;
        tick();
        check("midrst_wraps", wraps, 0);
        check("midrst_wraps_w2", wraps2, 0);
        check("midrst_err_jump", err_jump, 0);
        check("midrst_err_stall", err_stall, 0);
        check("midrst_locked", locked, 0);
        check("midrst_last_good", last_good, 0);
        Reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
